// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, initial hash value
// and datapath geometry used by the round controller and its neighbours.
package sha256_pkg;

  localparam int ROUND_W   = 6;
  localparam int MSG_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [7:0][31:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage

// File: rtl/sha256_k_table.sv
// SHA-256 round-constant ROM: K[t] as a purely combinational lookup on t.
module sha256_k_table
  import sha256_pkg::*;
(
  input  logic [ROUND_W-1:0] round_i,
  output logic [31:0]        k_o
);

  always_comb begin
    k_o = 32'h428a2f98;
    case (round_i)
      6'd0:  k_o = 32'h428a2f98; 6'd1:  k_o = 32'h71374491;
      6'd2:  k_o = 32'hb5c0fbcf; 6'd3:  k_o = 32'he9b5dba5;
      6'd4:  k_o = 32'h3956c25b; 6'd5:  k_o = 32'h59f111f1;
      6'd6:  k_o = 32'h923f82a4; 6'd7:  k_o = 32'hab1c5ed5;
      6'd8:  k_o = 32'hd807aa98; 6'd9:  k_o = 32'h12835b01;
      6'd10: k_o = 32'h243185be; 6'd11: k_o = 32'h550c7dc3;
      6'd12: k_o = 32'h72be5d74; 6'd13: k_o = 32'h80deb1fe;
      6'd14: k_o = 32'h9bdc06a7; 6'd15: k_o = 32'hc19bf174;
      6'd16: k_o = 32'he49b69c1; 6'd17: k_o = 32'hefbe4786;
      6'd18: k_o = 32'h0fc19dc6; 6'd19: k_o = 32'h240ca1cc;
      6'd20: k_o = 32'h2de92c6f; 6'd21: k_o = 32'h4a7484aa;
      6'd22: k_o = 32'h5cb0a9dc; 6'd23: k_o = 32'h76f988da;
      6'd24: k_o = 32'h983e5152; 6'd25: k_o = 32'ha831c66d;
      6'd26: k_o = 32'hb00327c8; 6'd27: k_o = 32'hbf597fc7;
      6'd28: k_o = 32'hc6e00bf3; 6'd29: k_o = 32'hd5a79147;
      6'd30: k_o = 32'h06ca6351; 6'd31: k_o = 32'h14292967;
      6'd32: k_o = 32'h27b70a85; 6'd33: k_o = 32'h2e1b2138;
      6'd34: k_o = 32'h4d2c6dfc; 6'd35: k_o = 32'h53380d13;
      6'd36: k_o = 32'h650a7354; 6'd37: k_o = 32'h766a0abb;
      6'd38: k_o = 32'h81c2c92e; 6'd39: k_o = 32'h92722c85;
      6'd40: k_o = 32'ha2bfe8a1; 6'd41: k_o = 32'ha81a664b;
      6'd42: k_o = 32'hc24b8b70; 6'd43: k_o = 32'hc76c51a3;
      6'd44: k_o = 32'hd192e819; 6'd45: k_o = 32'hd6990624;
      6'd46: k_o = 32'hf40e3585; 6'd47: k_o = 32'h106aa070;
      6'd48: k_o = 32'h19a4c116; 6'd49: k_o = 32'h1e376c08;
      6'd50: k_o = 32'h2748774c; 6'd51: k_o = 32'h34b0bcb5;
      6'd52: k_o = 32'h391c0cb3; 6'd53: k_o = 32'h4ed8aa4a;
      6'd54: k_o = 32'h5b9cca4f; 6'd55: k_o = 32'h682e6ff3;
      6'd56: k_o = 32'h748f82ee; 6'd57: k_o = 32'h78a5636f;
      6'd58: k_o = 32'h84c87814; 6'd59: k_o = 32'h8cc70208;
      6'd60: k_o = 32'h90befffa; 6'd61: k_o = 32'ha4506ceb;
      6'd62: k_o = 32'hbef9a3f7; 6'd63: k_o = 32'hc67178f2;
      default: k_o = 32'h428a2f98;
    endcase
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts a block, steps the round counter
// and issues load/round/update/digest controls to the hash datapath.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               block_valid_i,
  input  logic               first_block_i,
  input  logic               last_block_i,
  output logic               block_ready_o,
  output logic [ROUND_W-1:0] round_o,
  output logic [31:0]        k_o,
  output logic               load_work_o,
  output logic               init_hash_o,
  output logic               w_src_sel_o,
  output logic               round_en_o,
  output logic               update_hash_o,
  output logic               digest_valid_o,
  input  logic               digest_ready_i,
  output logic               busy_o
);

  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] MSG_LIMIT = ROUND_W'(MSG_WORDS);

  state_e             state_q;
  logic [ROUND_W-1:0] cnt_q;
  logic               chain_q;
  logic               first_q;
  logic               last_q;

  // Controller state, round counter and message-chain flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ROUND_W{1'b0}};
      chain_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ROUND_W{1'b0}};
      chain_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (block_valid_i) begin
            first_q <= first_block_i || !chain_q;
            last_q  <= last_block_i;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          chain_q <= 1'b1;
          cnt_q   <= {ROUND_W{1'b0}};
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          if (cnt_q == LAST_RND) begin
            cnt_q   <= {ROUND_W{1'b0}};
            state_q <= ST_UPDATE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        ST_UPDATE: begin
          if (last_q) begin
            chain_q <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (digest_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= {ROUND_W{1'b0}};
          chain_q <= 1'b0;
        end
      endcase
    end
  end

  // Every control is a pure decode of registered state; no input reaches an output.
  assign block_ready_o  = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign load_work_o    = (state_q == ST_INIT);
  assign init_hash_o    = (state_q == ST_INIT) && first_q;
  assign round_en_o     = (state_q == ST_ROUND);
  assign round_o        = (state_q == ST_ROUND) ? cnt_q : {ROUND_W{1'b0}};
  assign w_src_sel_o    = (state_q == ST_ROUND) && (cnt_q < MSG_LIMIT);
  assign update_hash_o  = (state_q == ST_UPDATE);
  assign digest_valid_o = (state_q == ST_DONE);

  sha256_k_table u_k_table (
    .round_i (round_o),
    .k_o     (k_o)
  );

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It accepts one 512-bit message block per valid/ready handshake and steps the round counter through the compression rounds. It also drives the round-constant lookup and issues the load, round, hash-update and digest-valid controls that the working-register and message-schedule datapath consumes. It sits between the block-feeding front end and the hash datapath, and owns no data registers itself.

## Interface
- NUM_ROUNDS, default 64: rounds per block. Legal range 17..64. Values below 64 exist only for reduced-round test vectors.
- clk_i  in  1  clock. Rising edge is active.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- clear_i  in  1  synchronous abort. Returns the controller to IDLE and ends the current chain.
- block_valid_i  in  1  the front end presents a block.
- first_block_i  in  1  sampled with the handshake. Starts a new message, so the hash registers load from the IV.
- last_block_i  in  1  sampled with the handshake. The digest is final after this block.
- block_ready_o  out  1  the controller can accept a block.
- round_o  out  6  current round index.
- k_o  out  32  round constant for round_o.
- load_work_o  out  1  load a..h: from the IV if init_hash_o=1, otherwise from H.
- init_hash_o  out  1  qualifies load_work_o. Also loads the IV into H.
- w_src_sel_o  out  1  1 = message word W[t] taken from the block (t<16); 0 = schedule recurrence.
- round_en_o  out  1  advance the compression one round.
- update_hash_o  out  1  H += a..h.
- digest_valid_o  out  1  H holds the final digest.
- digest_ready_i  in  1  the consumer takes the digest.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, INIT, ROUND, UPDATE, DONE.
- IDLE
  - block_ready_o=1.
  - On block_valid_i && block_ready_o: latch first_q = first_block_i || !chain_active, latch last_q = last_block_i, then go to INIT.
- INIT (one cycle)
  - load_work_o=1 and init_hash_o=first_q.
  - Set chain_active=1, then go to ROUND with the counter at 0.
- ROUND
  - round_en_o=1, round_o=counter, w_src_sel_o=(counter<16).
  - When counter==NUM_ROUNDS-1, go to UPDATE. Otherwise the counter increments by 1.
  - The counter never wraps and never exceeds 63.
- UPDATE (one cycle)
  - update_hash_o=1.
  - If last_q: go to DONE and clear chain_active. Otherwise go to IDLE.
- DONE
  - digest_valid_o=1, held until digest_ready_i. When it is seen, go to IDLE.
  - A digest_ready_i that arrives while digest_valid_o=0 is ignored.
- block_valid_i outside IDLE is ignored; it is not stored.
- A non-first block with no active chain is treated as first, so init_hash_o is asserted.
- clear_i has priority over every transition:
  - next state is IDLE, chain_active clears, the counter returns to 0;
  - no update_hash_o is issued;
  - if clear_i coincides with a handshake, the block is not accepted.
- Outside ROUND, round_o=0 and k_o=32'h428a2f98. k_o is a purely combinational function of round_o.

## Timing
- Reset values: state=IDLE, counter=0, chain_active=0. Consequently:
  - block_ready_o=1;
  - all other 1-bit outputs are 0;
  - round_o=0, k_o=32'h428a2f98.
- Reset asserted mid-operation aborts immediately and asynchronously to the reset values.
- Handshake accepted in cycle T:
  - INIT in T+1;
  - ROUND in T+2..T+1+NUM_ROUNDS;
  - UPDATE in T+2+NUM_ROUNDS;
  - then IDLE, or DONE in T+3+NUM_ROUNDS.
- With NUM_ROUNDS=64: UPDATE at T+66, digest_valid_o from T+67, next block accepted no earlier than T+67.
- Back-to-back non-last blocks: 67 cycles per block.
- All outputs are decoded from registered state and counter. There is no combinational path from inputs to outputs except k_o from round_o.

## Structure
- Shared package sha256_pkg holds:
  - the state enum (3-bit);
  - the SHA-256 IV constants;
  - localparam ROUND_W=6;
  - localparam MSG_WORDS=16.
- Sub-module: one instance of the existing sha256_k_table, driven by round_o, output to k_o.
- Everything else (FSM, counter, chain flag) is flat in this module.

## Test plan
- Single block: first=1, last=1, NUM_ROUNDS=64.
  - Exactly 1 load_work_o pulse with init_hash_o=1, followed by 64 round_en_o cycles.
  - round_o steps 0..63 and k_o matches the constant at rounds 0, 15, 16 and 63 (32'hc67178f2).
  - w_src_sel_o is high for exactly 16 cycles.
  - update_hash_o pulses at T+66 and digest_valid_o rises at T+67.
- Two-block message, block_valid_i held high:
  - second handshake at T+67;
  - second INIT has init_hash_o=0;
  - DONE only after the second UPDATE at T+133.
- Backpressure: digest_ready_i held low for 10 cycles.
  - digest_valid_o stays high and block_ready_o stays 0;
  - on ready, IDLE follows in the next cycle.
- clear_i asserted at round 30:
  - next cycle is IDLE with round_o=0;
  - no update_hash_o pulse;
  - a following block with first=0 still gets init_hash_o=1.
- Async reset at round 40:
  - outputs reach reset values without a clock edge;
  - a block arriving while busy is ignored, with no extra INIT.
- NUM_ROUNDS=20: UPDATE at T+22 and round_o peaks at 19.
